// File: rtl/avalon_mem_burst_split_pkg.sv
// Shared types and helpers for the Avalon-MM local-memory burst splitter.
package avalon_mem_burst_split_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_SPLIT
  } t_split_state;

  // Length of the next FIM burst: the remaining count clipped to the FIM
  // maximum. A zero count is treated as a single line.
  function automatic int unsigned chunk_len(input int unsigned n, input int unsigned max_burst);
    int unsigned n_eff;
    n_eff = (n == 0) ? 1 : n;
    return (n_eff < max_burst) ? n_eff : max_burst;
  endfunction

endpackage

// File: rtl/avalon_mem_rd_credit.sv
// Read-credit tracker: counts read beats issued to the FIM but not yet
// returned, and says whether a burst of req_len more beats still fits.
module avalon_mem_rd_credit #(
  parameter int MAX_RD_IN_FLIGHT = 64,
  parameter int LEN_WIDTH        = 3,
  parameter int CNT_WIDTH        = $clog2(MAX_RD_IN_FLIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue,
  input  logic [LEN_WIDTH-1:0] issue_len,
  input  logic [LEN_WIDTH-1:0] req_len,
  input  logic                 rsp_valid,
  output logic                 can_issue
);

  localparam logic [31:0] MAX_U = 32'(MAX_RD_IN_FLIGHT);

  logic [CNT_WIDTH-1:0] out_cnt_reg;
  logic [CNT_WIDTH-1:0] out_cnt_next;

  // Issue and return can land in the same cycle; apply both.
  always_comb begin
    out_cnt_next = out_cnt_reg;
    if (issue) begin
      out_cnt_next = out_cnt_next + CNT_WIDTH'(issue_len);
    end
    if (rsp_valid) begin
      out_cnt_next = out_cnt_next - CNT_WIDTH'(1);
    end
  end

  // Outstanding-beat counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt_reg <= '0;
    end else begin
      out_cnt_reg <= out_cnt_next;
    end
  end

  // Uses the registered count only: a beat returning this cycle frees its
  // credit one cycle later, which keeps the compare off the response path.
  assign can_issue = (32'(out_cnt_reg) + 32'(req_len)) <= MAX_U;

endmodule

// File: rtl/avalon_mem_burst_splitter.sv
// Avalon-MM burst adapter: splits long AFU bursts into FIM bursts of at most
// SOURCE_MAX_BURST lines and throttles reads with a beat credit counter.
// Read data returns in order and is passed straight through.
module avalon_mem_burst_splitter
  import avalon_mem_burst_split_pkg::*;
#(
  parameter int ADDR_WIDTH             = 27,
  parameter int DATA_WIDTH             = 512,
  parameter int SINK_BURST_CNT_WIDTH   = 7,
  parameter int SOURCE_BURST_CNT_WIDTH = 3,
  parameter int SOURCE_MAX_BURST       = 4,
  parameter int MAX_RD_IN_FLIGHT       = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic                              sink_waitrequest,
  output logic [DATA_WIDTH-1:0]             sink_readdata,
  output logic                              sink_readdatavalid,
  input  logic [SINK_BURST_CNT_WIDTH-1:0]   sink_burstcount,
  input  logic [DATA_WIDTH-1:0]             sink_writedata,
  input  logic [ADDR_WIDTH-1:0]             sink_address,
  input  logic                              sink_write,
  input  logic                              sink_read,
  input  logic [DATA_WIDTH/8-1:0]           sink_byteenable,
  input  logic                              source_waitrequest,
  input  logic [DATA_WIDTH-1:0]             source_readdata,
  input  logic                              source_readdatavalid,
  output logic [SOURCE_BURST_CNT_WIDTH-1:0] source_burstcount,
  output logic [DATA_WIDTH-1:0]             source_writedata,
  output logic [ADDR_WIDTH-1:0]             source_address,
  output logic                              source_write,
  output logic                              source_read,
  output logic [DATA_WIDTH/8-1:0]           source_byteenable
);

  localparam int SW = SINK_BURST_CNT_WIDTH;
  localparam int OW = SOURCE_BURST_CNT_WIDTH;
  localparam int unsigned MAXB = SOURCE_MAX_BURST;
  localparam logic [SW-1:0] MAX_BURST_SW = SW'(SOURCE_MAX_BURST);

  t_split_state state_reg, state_next;
  logic [SW-1:0] tot_left_reg, tot_left_next;
  logic [SW-1:0] sub_left_reg, sub_left_next;
  logic [SW-1:0] rd_left_reg, rd_left_next;
  logic [ADDR_WIDTH-1:0] next_addr_reg, next_addr_next;

  logic [SW-1:0] n_eff;
  logic [SW-1:0] first_len;
  logic [SW-1:0] tot_len;
  logic [SW-1:0] rd_len;
  logic [OW-1:0] req_len;
  logic          can_issue;
  logic          rd_issue;

  assign n_eff     = (sink_burstcount == '0) ? SW'(1) : sink_burstcount;
  assign first_len = SW'(chunk_len(32'(n_eff), MAXB));
  assign tot_len   = SW'(chunk_len(32'(tot_left_reg), MAXB));
  assign rd_len    = SW'(chunk_len(32'(rd_left_reg), MAXB));
  assign req_len   = (state_reg == RD_SPLIT) ? OW'(rd_len) : OW'(first_len);
  assign rd_issue  = source_read & ~source_waitrequest;

  assign source_writedata   = sink_writedata;
  assign source_byteenable  = sink_byteenable;
  assign sink_readdata      = source_readdata;
  assign sink_readdatavalid = source_readdatavalid & ~reset;

  avalon_mem_rd_credit #(
    .MAX_RD_IN_FLIGHT(MAX_RD_IN_FLIGHT),
    .LEN_WIDTH       (OW)
  ) u_credit (
    .clk      (clk),
    .reset    (reset),
    .issue    (rd_issue),
    .issue_len(source_burstcount),
    .req_len  (req_len),
    .rsp_valid(source_readdatavalid),
    .can_issue(can_issue)
  );

  // Next-state and command mux; IDLE forwards the AFU command with no added latency.
  always_comb begin
    state_next        = state_reg;
    tot_left_next     = tot_left_reg;
    sub_left_next     = sub_left_reg;
    rd_left_next      = rd_left_reg;
    next_addr_next    = next_addr_reg;
    source_read       = 1'b0;
    source_write      = 1'b0;
    source_address    = sink_address;
    source_burstcount = OW'(first_len);
    sink_waitrequest  = 1'b1;

    case (state_reg)
      IDLE: begin
        if (sink_write) begin
          source_write     = 1'b1;
          sink_waitrequest = source_waitrequest;
          if (!source_waitrequest && (n_eff > SW'(1))) begin
            state_next     = WR_BURST;
            tot_left_next  = n_eff - SW'(1);
            sub_left_next  = first_len - SW'(1);
            next_addr_next = sink_address + ADDR_WIDTH'(first_len);
          end
        end else if (sink_read) begin
          source_read      = can_issue;
          sink_waitrequest = source_waitrequest | ~can_issue | (n_eff > MAX_BURST_SW);
          if (can_issue && !source_waitrequest && (n_eff > MAX_BURST_SW)) begin
            state_next     = RD_SPLIT;
            rd_left_next   = n_eff - first_len;
            next_addr_next = sink_address + ADDR_WIDTH'(first_len);
          end
        end
      end

      WR_BURST: begin
        // Address/burstcount only matter on header beats (sub_left_reg == 0).
        source_write      = sink_write;
        sink_waitrequest  = source_waitrequest;
        source_address    = next_addr_reg;
        source_burstcount = OW'(tot_len);
        if (sink_write && !source_waitrequest) begin
          tot_left_next = tot_left_reg - SW'(1);
          if (sub_left_reg == '0) begin
            sub_left_next  = tot_len - SW'(1);
            next_addr_next = next_addr_reg + ADDR_WIDTH'(tot_len);
          end else begin
            sub_left_next = sub_left_reg - SW'(1);
          end
          if (tot_left_reg == SW'(1)) begin
            state_next = IDLE;
          end
        end
      end

      RD_SPLIT: begin
        source_read       = can_issue;
        source_address    = next_addr_reg;
        source_burstcount = OW'(rd_len);
        if (can_issue && !source_waitrequest) begin
          rd_left_next   = rd_left_reg - rd_len;
          next_addr_next = next_addr_reg + ADDR_WIDTH'(rd_len);
          if (rd_left_reg <= MAX_BURST_SW) begin
            sink_waitrequest = 1'b0;
            state_next       = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    if (reset) begin
      sink_waitrequest = 1'b1;
      source_read      = 1'b0;
      source_write     = 1'b0;
    end
  end

  // FSM and burst bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      tot_left_reg  <= '0;
      sub_left_reg  <= '0;
      rd_left_reg   <= '0;
      next_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      tot_left_reg  <= tot_left_next;
      sub_left_reg  <= sub_left_next;
      rd_left_reg   <= rd_left_next;
      next_addr_reg <= next_addr_next;
    end
  end

  // A zero burstcount or simultaneous read and write is an AFU protocol error.
  a_no_zero_burst: assert property (@(posedge clk) disable iff (reset)
    (state_reg == IDLE && (sink_read || sink_write)) |-> (sink_burstcount != '0));
  a_no_rd_and_wr: assert property (@(posedge clk) disable iff (reset)
    !(sink_read && sink_write));

endmodule
